// File: rtl/core_div.sv
// core_div: multi-cycle restoring radix-2 divider, signed/unsigned, one quotient bit per clock.
// Optional: define CORE_DIV_ZERO_TRAP_EN to bypass the iteration for a zero divisor.
`default_nettype none

module core_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         sig_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] q_o,
  output logic [W-1:0] r_o,
  output logic         z_o,
  output logic         n_o,
  output logic         div_zero_o,
  output logic         busy_o,
  output logic         rdy_o
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [W-1:0]   rem_q;
  logic [W-1:0]   dvd_q;
  logic [W-1:0]   dvs_q;
  logic [W-1:0]   a_raw_q;
  logic           sign_q_q;
  logic           sign_r_q;
  logic           bzero_q;

  logic [W-1:0]   a_mag_d;
  logic [W-1:0]   b_mag_d;
  logic [W:0]     rem_sh_d;
  logic           ge_d;
  logic [W:0]     rem_nx_d;
  logic [W-1:0]   q_fix_d;
  logic [W-1:0]   r_fix_d;

  // The remainder register never exceeds the divisor, so only the shifted trial value needs W+1 bits.
  always_comb begin
    a_mag_d  = (sig_i && a_i[W-1]) ? -a_i : a_i;
    b_mag_d  = (sig_i && b_i[W-1]) ? -b_i : b_i;
    rem_sh_d = {rem_q, dvd_q[W-1]};
    ge_d     = (rem_sh_d >= {1'b0, dvs_q});
    rem_nx_d = ge_d ? (rem_sh_d - {1'b0, dvs_q}) : rem_sh_d;
    q_fix_d  = bzero_q ? {W{1'b1}} : (sign_q_q ? -dvd_q : dvd_q);
    r_fix_d  = bzero_q ? a_raw_q   : (sign_r_q ? -rem_q : rem_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      a_raw_q    <= '0;
      sign_q_q   <= 1'b0;
      sign_r_q   <= 1'b0;
      bzero_q    <= 1'b0;
      q_o        <= '0;
      r_o        <= '0;
      z_o        <= 1'b1;
      n_o        <= 1'b0;
      div_zero_o <= 1'b0;
      busy_o     <= 1'b0;
      rdy_o      <= 1'b0;
    end else begin
      rdy_o <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            a_raw_q  <= a_i;
            dvd_q    <= a_mag_d;
            dvs_q    <= b_mag_d;
            rem_q    <= '0;
            cnt_q    <= CW'(W);
            sign_q_q <= sig_i & (a_i[W-1] ^ b_i[W-1]);
            sign_r_q <= sig_i & a_i[W-1];
            bzero_q  <= (b_i == '0);
            busy_o   <= 1'b1;
`ifdef CORE_DIV_ZERO_TRAP_EN
            state_q  <= (b_i == '0) ? S_FIX : S_RUN;
`else
            state_q  <= S_RUN;
`endif
          end
        end
        S_RUN: begin
          rem_q <= rem_nx_d[W-1:0];
          dvd_q <= {dvd_q[W-2:0], ge_d};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CW'(1)) state_q <= S_FIX;
        end
        S_FIX: begin
          q_o        <= q_fix_d;
          r_o        <= r_fix_d;
          z_o        <= (q_fix_d == '0);
          n_o        <= q_fix_d[W-1];
          div_zero_o <= bzero_q;
          rdy_o      <= 1'b1;
          busy_o     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_div.sv
// tb_core_div: directed self-checking bench for core_div (W=32).
`default_nettype none

module tb_core_div;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        sig_i = 1'b0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic [31:0] q_o, r_o;
  logic        z_o, n_o, div_zero_o, busy_o, rdy_o;

  int checks = 0;
  int failures = 0;

`ifdef CORE_DIV_ZERO_TRAP_EN
  localparam int DZ_LAT = 1;
`else
  localparam int DZ_LAT = 33;
`endif

  core_div #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .sig_i(sig_i), .a_i(a_i), .b_i(b_i),
    .q_o(q_o), .r_o(r_o), .z_o(z_o), .n_o(n_o), .div_zero_o(div_zero_o),
    .busy_o(busy_o), .rdy_o(rdy_o)
  );

  always #5 clk = ~clk;

  // Drives a request so that the next posedge is E0; returns 1 ns after E0.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    @(negedge clk);
    a_i = a; b_i = b; sig_i = s; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; a_i = $urandom; b_i = $urandom; sig_i = ~s;
  endtask

  task automatic wait_rdy(input int limit, output int lat);
    lat = -1;
    for (int k = 1; k <= limit; k++) begin
      @(posedge clk); #1;
      if (rdy_o) begin lat = k; break; end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (q_o !== 32'd0) begin failures++; $display("FAIL reset_q got=%h exp=0", q_o); end
    checks++; if (r_o !== 32'd0) begin failures++; $display("FAIL reset_r got=%h exp=0", r_o); end
    checks++; if (z_o !== 1'b1) begin failures++; $display("FAIL reset_z got=%b exp=1", z_o); end
    checks++; if ({n_o, div_zero_o, busy_o, rdy_o} !== 4'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=0000", {n_o, div_zero_o, busy_o, rdy_o}); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_unsigned;
    int lat;
    launch(32'd100, 32'd7, 1'b0);
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL u_busy got=%b exp=1", busy_o); end
    wait_rdy(40, lat);
    checks++; if (lat !== 33) begin failures++; $display("FAIL u_latency got=%0d exp=33", lat); end
    checks++; if (q_o !== 32'd14) begin failures++; $display("FAIL u_q got=%h exp=%h", q_o, 32'd14); end
    checks++; if (r_o !== 32'd2) begin failures++; $display("FAIL u_r got=%h exp=%h", r_o, 32'd2); end
    checks++; if ({z_o, n_o, div_zero_o, busy_o} !== 4'b0000) begin
      failures++; $display("FAIL u_flags got=%b exp=0000", {z_o, n_o, div_zero_o, busy_o}); end
    @(posedge clk); #1;
    checks++; if (rdy_o !== 1'b0) begin failures++; $display("FAIL u_rdy_width got=%b exp=0", rdy_o); end
    checks++; if (q_o !== 32'd14) begin failures++; $display("FAIL u_q_hold got=%h exp=%h", q_o, 32'd14); end
  endtask

  task automatic test_signed;
    int lat;
    launch(32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_rdy(40, lat);
    checks++; if (lat !== 33) begin failures++; $display("FAIL s_latency got=%0d exp=33", lat); end
    checks++; if (q_o !== 32'hFFFF_FFFD) begin failures++; $display("FAIL s_q got=%h exp=fffffffd", q_o); end
    checks++; if (r_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL s_r got=%h exp=ffffffff", r_o); end
    checks++; if ({z_o, n_o, div_zero_o} !== 3'b010) begin
      failures++; $display("FAIL s_flags got=%b exp=010", {z_o, n_o, div_zero_o}); end
    launch(32'hFFFF_FFF9, 32'd2, 1'b0);
    wait_rdy(40, lat);
    checks++; if (q_o !== 32'h7FFF_FFFC) begin failures++; $display("FAIL us_q got=%h exp=7ffffffc", q_o); end
    checks++; if (r_o !== 32'd1) begin failures++; $display("FAIL us_r got=%h exp=1", r_o); end
    checks++; if (n_o !== 1'b0) begin failures++; $display("FAIL us_n got=%b exp=0", n_o); end
    launch(32'd20, 32'hFFFF_FFFD, 1'b1);
    wait_rdy(40, lat);
    checks++; if (q_o !== 32'hFFFF_FFFA) begin failures++; $display("FAIL s_negb_q got=%h exp=fffffffa", q_o); end
    checks++; if (r_o !== 32'd2) begin failures++; $display("FAIL s_negb_r got=%h exp=2", r_o); end
    launch(32'd3, 32'd9, 1'b0);
    wait_rdy(40, lat);
    checks++; if ({q_o, z_o} !== {32'd0, 1'b1}) begin failures++; $display("FAIL zero_q got=%h z=%b exp=0 z=1", q_o, z_o); end
    checks++; if (r_o !== 32'd3) begin failures++; $display("FAIL zero_r got=%h exp=3", r_o); end
  endtask

  task automatic test_overflow;
    int lat;
    launch(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_rdy(40, lat);
    checks++; if (q_o !== 32'h8000_0000) begin failures++; $display("FAIL ovf_q got=%h exp=80000000", q_o); end
    checks++; if (r_o !== 32'd0) begin failures++; $display("FAIL ovf_r got=%h exp=0", r_o); end
    checks++; if ({z_o, n_o, div_zero_o} !== 3'b010) begin
      failures++; $display("FAIL ovf_flags got=%b exp=010", {z_o, n_o, div_zero_o}); end
  endtask

  task automatic test_div_zero;
    int lat;
    launch(32'd5, 32'd0, 1'b1);
    wait_rdy(40, lat);
    checks++; if (lat !== DZ_LAT) begin failures++; $display("FAIL dz_latency got=%0d exp=%0d", lat, DZ_LAT); end
    checks++; if (q_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_q got=%h exp=ffffffff", q_o); end
    checks++; if (r_o !== 32'd5) begin failures++; $display("FAIL dz_r got=%h exp=5", r_o); end
    checks++; if (div_zero_o !== 1'b1) begin failures++; $display("FAIL dz_flag got=%b exp=1", div_zero_o); end
    launch(32'd9, 32'd3, 1'b0);
    wait_rdy(40, lat);
    checks++; if ({q_o, div_zero_o} !== {32'd3, 1'b0}) begin
      failures++; $display("FAIL dz_clear got=%h dz=%b exp=3 dz=0", q_o, div_zero_o); end
  endtask

  task automatic test_start_ignored;
    int lat = -1;
    launch(32'd100, 32'd7, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin a_i = 32'd1; b_i = 32'd1; sig_i = 1'b0; start_i = 1'b1; end
      @(posedge clk); #1;
      start_i = 1'b0;
      if (rdy_o) begin lat = k; break; end
    end
    checks++; if (lat !== 33) begin failures++; $display("FAIL ign_latency got=%0d exp=33", lat); end
    checks++; if ({q_o, r_o} !== {32'd14, 32'd2}) begin
      failures++; $display("FAIL ign_result got=%h/%h exp=e/2", q_o, r_o); end
  endtask

  task automatic test_back_to_back;
    int lat;
    launch(32'd50, 32'd5, 1'b0);
    wait_rdy(40, lat);
    checks++; if (q_o !== 32'd10) begin failures++; $display("FAIL b2b_q1 got=%h exp=a", q_o); end
    a_i = 32'd20; b_i = 32'd3; sig_i = 1'b0; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    checks++; if ({busy_o, rdy_o} !== 2'b10) begin
      failures++; $display("FAIL b2b_accept got=%b exp=10", {busy_o, rdy_o}); end
    wait_rdy(40, lat);
    checks++; if (lat !== 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    checks++; if ({q_o, r_o} !== {32'd6, 32'd2}) begin
      failures++; $display("FAIL b2b_result got=%h/%h exp=6/2", q_o, r_o); end
  endtask

  task automatic test_async_reset;
    int seen = 0;
    launch(32'd100, 32'd7, 1'b0);
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy_o, rdy_o, z_o} !== 3'b001) begin
      failures++; $display("FAIL ar_flags got=%b exp=001", {busy_o, rdy_o, z_o}); end
    checks++; if (q_o !== 32'd0) begin failures++; $display("FAIL ar_q got=%h exp=0", q_o); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 45; k++) begin
      @(posedge clk); #1;
      if (rdy_o || busy_o) seen++;
    end
    checks++; if (seen !== 0) begin failures++; $display("FAIL ar_quiet got=%0d exp=0", seen); end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_div_zero();
    test_start_ignored();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
